// File: rtl/hilo_muldiv_sequencer_if.sv
// Execute-stage bundle between the pipeline and the HI/LO multiply/divide sequencer.
// The pipeline side (master) presents instructions; the sequencer side (slave) returns HI/LO and status.
interface hilo_muldiv_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              instr_valid;
   logic [5:0]        func_code;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic              busy;
   logic              stall;
   logic              done;

   modport master (
      output instr_valid, func_code, rs_data, rt_data,
      input  hi, lo, busy, stall, done
   );

   modport slave (
      input  instr_valid, func_code, rs_data, rt_data,
      output hi, lo, busy, stall, done
   );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// HI/LO owner for the execute stage: MTHI/MTLO writes plus a bit-serial shift-add
// multiplier and restoring divider with fixed DATA_W+1 cycle latency.
//
// state | meaning
// IDLE  | accepting HI/LO instructions, busy = 0
// MUL   | one shift-add step per cycle on operand magnitudes
// DIV   | one restoring-divide step per cycle on operand magnitudes
// FIX   | sign-correct the result, write HI/LO, pulse done
module hilo_muldiv_sequencer #(
   parameter int DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   hilo_muldiv_sequencer_if.slave bus
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   hi_r;
   logic [DATA_W-1:0]   lo_r;
   logic                busy_r;
   logic                done_r;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic [DATA_W-1:0]   acc_hi;
   logic [DATA_W-1:0]   acc_lo;
   logic                q_neg;
   logic                r_neg;
   logic                op_div;
   logic [CNT_W-1:0]    cnt;

   logic                hilo_op;
   logic                rs_neg;
   logic                rt_neg;
   logic [DATA_W-1:0]   rs_mag;
   logic [DATA_W-1:0]   rt_mag;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_diff;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   fix_hi;
   logic [DATA_W-1:0]   fix_lo;

   always_comb begin
      hilo_op = bus.instr_valid &&
                ((bus.func_code[5:2] == 4'b0100) || (bus.func_code[5:2] == 4'b0110));
      // func_code[0] == 0 selects the signed variants (MULT, DIV)
      rs_neg  = !bus.func_code[0] && bus.rs_data[DATA_W-1];
      rt_neg  = !bus.func_code[0] && bus.rt_data[DATA_W-1];
      rs_mag  = rs_neg ? -bus.rs_data : bus.rs_data;
      rt_mag  = rt_neg ? -bus.rt_data : bus.rt_data;
   end

   // {acc_hi, acc_lo} is the product during MUL; remainder/quotient during DIV
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_mag} : {(DATA_W+1){1'b0}});
      div_shift = {acc_hi, acc_lo[DATA_W-1]};
      div_diff  = div_shift - {1'b0, b_mag};
   end

   always_comb begin
      prod_fix = q_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      if (!op_div) begin
         fix_hi = prod_fix[2*DATA_W-1:DATA_W];
         fix_lo = prod_fix[DATA_W-1:0];
      end else if (b_mag == '0) begin
         // r_neg is the dividend sign, so this reconstructs rs as latched
         fix_hi = r_neg ? -a_mag : a_mag;
         fix_lo = '1;
      end else begin
         fix_hi = r_neg ? -acc_hi : acc_hi;
         fix_lo = q_neg ? -acc_lo : acc_lo;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         hi_r   <= '0;
         lo_r   <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         a_mag  <= '0;
         b_mag  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         op_div <= 1'b0;
         cnt    <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (hilo_op) begin
                  case (bus.func_code)
                     F_MTHI: hi_r <= bus.rs_data;
                     F_MTLO: lo_r <= bus.rs_data;
                     F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        a_mag  <= rs_mag;
                        b_mag  <= rt_mag;
                        q_neg  <= rs_neg ^ rt_neg;
                        r_neg  <= rs_neg;
                        op_div <= bus.func_code[1];
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        acc_hi <= '0;
                        if (bus.func_code[1]) begin
                           acc_lo <= rs_mag;
                           state  <= ST_DIV;
                        end else begin
                           acc_lo <= rt_mag;
                           state  <= ST_MUL;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               acc_hi <= mul_sum[DATA_W:1];
               acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
               cnt    <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_W-1)) state <= ST_FIX;
            end
            ST_DIV: begin
               if (!div_diff[DATA_W]) begin
                  acc_hi <= div_diff[DATA_W-1:0];
                  acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
               end else begin
                  acc_hi <= div_shift[DATA_W-1:0];
                  acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(DATA_W-1)) state <= ST_FIX;
            end
            ST_FIX: begin
               hi_r   <= fix_hi;
               lo_r   <= fix_lo;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.hi    = hi_r;
   assign bus.lo    = lo_r;
   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.stall = hilo_op & busy_r;

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Bench for hilo_muldiv_sequencer: directed vector table, hand-written stall/reset
// sequences, and randomized ops checked against an arithmetic reference model.
module tb_hilo_muldiv_sequencer;

   localparam int W = 32;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_ADDU  = 6'b100001;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   hilo_muldiv_sequencer_if #(.DATA_W(W)) bus ();

   hilo_muldiv_sequencer #(.DATA_W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [5:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp_hi;
      logic [W-1:0] exp_lo;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.instr_valid = v;
      bus.func_code   = f;
      bus.rs_data     = a;
      bus.rt_data     = b;
   endtask

   // Presents one mult/div, then follows busy until it drops (bounded).
   task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int nbusy, output int ndone,
                         output logic [W-1:0] h, output logic [W-1:0] l);
      drive(1'b1, f, a, b);
      tick();
      drive(1'b0, 6'b0, '0, '0);
      nbusy = 0;
      ndone = 0;
      while (bus.busy && nbusy < 100) begin
         nbusy++;
         if (bus.done) ndone++;
         tick();
      end
      if (bus.done) ndone++;
      h = bus.hi;
      l = bus.lo;
      tick();
      if (bus.done) ndone++;
   endtask

   function automatic void ref_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h  = '0;
      l  = '0;
      case (f)
         F_MULT: begin
            p = 64'(sa * sb);
            h = p[63:32];
            l = p[31:0];
         end
         F_MULTU: begin
            p = {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
         end
         F_DIV: begin
            if (b == 0) begin
               h = a;
               l = '1;
            end else begin
               q = sa / sb;
               r = sa % sb;
               l = q[31:0];
               h = r[31:0];
            end
         end
         F_DIVU: begin
            if (b == 0) begin
               h = a;
               l = '1;
            end else begin
               l = a / b;
               h = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t         vecs [9];
   int           nb;
   int           nd;
   int           ns;
   int           guard;
   logic [W-1:0] rh;
   logic [W-1:0] rl;
   logic [W-1:0] eh;
   logic [W-1:0] el;
   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;
   logic [W-1:0] ra;
   logic [W-1:0] rb;
   logic [5:0]   rf;

   initial begin
      vecs[0] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[2] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[4] = '{F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
      vecs[5] = '{F_MULT,  32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
      vecs[6] = '{F_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[7] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[8] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

      drive(1'b0, 6'b0, '0, '0);
      #3;
      chk("reset_hi", bus.hi, 0);
      chk("reset_lo", bus.lo, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      #9;
      reset = 1'b1;
      tick();

      foreach (vecs[i]) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, nb, nd, rh, rl);
         chk($sformatf("vec%0d_busy_cycles", i), nb, 33);
         chk($sformatf("vec%0d_done_pulses", i), nd, 1);
         chk($sformatf("vec%0d_hi", i), rh, vecs[i].exp_hi);
         chk($sformatf("vec%0d_lo", i), rl, vecs[i].exp_lo);
      end

      // MFLO arriving mid-multiply stalls until the result lands
      drive(1'b1, F_MULT, 32'hFFFFFFFD, 32'h5);
      tick();
      drive(1'b0, 6'b0, '0, '0);
      repeat (4) tick();
      drive(1'b1, F_MFLO, '0, '0);
      #1;
      ns = 0;
      guard = 0;
      while (bus.busy && guard < 100) begin
         if (bus.stall) ns++;
         tick();
         #1;
         guard++;
      end
      chk("mflo_stall_cycles", ns, 29);
      chk("mflo_done", bus.done, 1);
      chk("mflo_stall_at_done", bus.stall, 0);
      chk("mflo_lo", bus.lo, 32'hFFFFFFF1);
      tick();
      drive(1'b0, 6'b0, '0, '0);

      // unrelated op flows while busy; MTHI waits and then lands after done
      drive(1'b1, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      drive(1'b1, F_ADDU, 32'h1, 32'h2);
      #1;
      chk("addu_no_stall", bus.stall, 0);
      tick();
      drive(1'b1, F_MTHI, 32'h5A5A5A5A, '0);
      #1;
      ns = 0;
      guard = 0;
      while (bus.busy && guard < 100) begin
         if (bus.stall) ns++;
         tick();
         #1;
         guard++;
      end
      chk("mthi_stall_cycles", ns, 32);
      chk("mthi_stall_at_done", bus.stall, 0);
      chk("mthi_hi_before", bus.hi, 32'hFFFFFFFE);
      chk("mthi_lo_before", bus.lo, 32'h00000001);
      tick();
      drive(1'b0, 6'b0, '0, '0);
      chk("mthi_hi_after", bus.hi, 32'h5A5A5A5A);
      chk("mthi_busy_after", bus.busy, 0);

      drive(1'b1, F_MTHI, 32'hA5A5A5A5, '0);
      tick();
      drive(1'b0, 6'b0, '0, '0);
      chk("idle_mthi_hi", bus.hi, 32'hA5A5A5A5);
      chk("idle_mthi_busy", bus.busy, 0);

      // reset in the middle of a divide
      drive(1'b1, F_DIVU, 32'h1234, 32'h3);
      tick();
      drive(1'b0, 6'b0, '0, '0);
      repeat (16) tick();
      chk("divu_busy_mid", bus.busy, 1);
      reset = 1'b0;
      #1;
      chk("midreset_hi", bus.hi, 0);
      chk("midreset_lo", bus.lo, 0);
      chk("midreset_busy", bus.busy, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      drive(1'b1, F_MTLO, 32'h7, '0);
      tick();
      drive(1'b0, 6'b0, '0, '0);
      chk("post_reset_mtlo_lo", bus.lo, 32'h7);
      chk("post_reset_hi", bus.hi, 0);
      chk("post_reset_busy", bus.busy, 0);

      m_hi = '0;
      m_lo = 32'h7;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 5))
            0: rf = F_MTHI;
            1: rf = F_MTLO;
            2: rf = F_MULT;
            3: rf = F_MULTU;
            4: rf = F_DIV;
            default: rf = F_DIVU;
         endcase
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 2) == 0) begin
            ra = $urandom_range(0, 300);
            rb = $urandom_range(0, 20);
            if ($urandom_range(0, 1) == 1) ra = -ra;
            if ($urandom_range(0, 1) == 1) rb = -rb;
         end
         if ($urandom_range(0, 7) == 0) rb = '0;
         if (rf == F_MTHI || rf == F_MTLO) begin
            drive(1'b1, rf, ra, '0);
            tick();
            drive(1'b0, 6'b0, '0, '0);
            if (rf == F_MTHI) m_hi = ra;
            else m_lo = ra;
            chk($sformatf("rnd%0d_mt_hi", k), bus.hi, m_hi);
            chk($sformatf("rnd%0d_mt_lo", k), bus.lo, m_lo);
         end else begin
            ref_op(rf, ra, rb, eh, el);
            m_hi = eh;
            m_lo = el;
            run_op(rf, ra, rb, nb, nd, rh, rl);
            chk($sformatf("rnd%0d_busy_cycles f=%b a=%h b=%h", k, rf, ra, rb), nb, 33);
            chk($sformatf("rnd%0d_hi f=%b a=%h b=%h", k, rf, ra, rb), rh, m_hi);
            chk($sformatf("rnd%0d_lo f=%b a=%h b=%h", k, rf, ra, rb), rl, m_lo);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_sequencer.md
Name: hilo_muldiv_sequencer

Overview:
Multi-cycle controller for the HI/LO special registers of the MIPS core. It decodes R-type function codes for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO and runs an iterative shift-add multiplier or a restoring divider, one bit per cycle. It owns the HI/LO registers and raises a pipeline stall when a HI/LO-touching instruction arrives while an operation is in flight. It sits beside the ALU in the execute stage; the register-file writeback path reads hi/lo directly.

Parameters:
DATA_W, 32, operand/HI/LO width; must be even and >= 8; iteration count equals DATA_W

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  execute-stage instruction valid (opcode == 0 already qualified upstream)
func_code  input  6  R-type function field
rs_data  input  DATA_W  operand A / MTHI-MTLO source
rt_data  input  DATA_W  operand B
hi  output  DATA_W  HI register
lo  output  DATA_W  LO register
busy  output  1  mult/div in progress
stall  output  1  hold execute stage this cycle
done  output  1  one-cycle pulse: HI/LO just updated by mult/div

Behaviour:
- Codes: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011. hilo_op = instr_valid & func_code in that set; other codes ignored.
- Reset (reset == 0, async): state IDLE, hi = lo = 0, busy = 0, done = 0, iteration counter = 0, internal accumulators = 0. Reset mid-operation aborts it; HI/LO do not retain the old value.
- stall = hilo_op & busy (combinational). A stalled instruction has no effect; the pipeline re-presents it.
- States: IDLE, MUL, DIV, FIX.
- IDLE, accepted instruction (hilo_op & !busy):
  - MTHI / MTLO: hi or lo <= rs_data at the next edge; state stays IDLE.
  - MFHI / MFLO: no state change; the consumer reads hi/lo.
  - MULT(U) / DIV(U): latch operands at edge E0. Signed ops store magnitudes plus result-sign flags (quotient/product sign = sign(rs) ^ sign(rt); remainder sign = sign(rs)). Unsigned ops clear the flags. Counter <= 0. Go to MUL or DIV. busy = 1 from E0.
- MUL: one shift-add step per edge E1..E_DATA_W into a 2*DATA_W product. After the last step, go to FIX.
- DIV: one restoring step per edge E1..E_DATA_W. If rt == 0, still run all DATA_W cycles with the result forced in FIX.
- FIX, edge E_(DATA_W+1): apply sign fix (two's-complement negate per flag), then write HI/LO:
  - MUL: HI = product[2W-1:W], LO = product[W-1:0].
  - DIV: LO = quotient, HI = remainder.
  - Divide by zero: LO = all ones, HI = rs_data as latched.
  - Go to IDLE, busy <= 0, done = 1 for exactly the following cycle.
- Fixed latency: HI/LO valid after edge DATA_W+1 counted from the accepting edge (33 for DATA_W = 32). A HI/LO instruction presented the cycle after done proceeds unstalled.
- DIV of INT_MIN / -1 yields LO = INT_MIN (0x80000000), HI = 0 with no special case.
- Unrelated instructions flow freely while busy.
- MTHI/MTLO during busy are stalled, never dropped or merged.

Test Plan:
- Reset, then MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high for 33 cycles; after edge 33 hi=0xFFFFFFFF, lo=0xFFFFFFF1; done pulses once.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 at edge 33.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x00001234 at edge 33; no X.
- Start MULT, present MFLO at cycle 5 -> stall=1 through cycle 33, stall=0 the cycle done=1, and lo holds the product. MTHI 0xA5A5A5A5 while idle -> hi updates next edge, busy stays 0.
- Drive reset low at cycle 17 of a DIVU -> hi=lo=0, busy=0 immediately; after release, MTLO 7 -> lo=7.
